// File: rtl/mdu_alu.sv
// rtl/mdu_alu.sv - EX-stage ALU with iterative multiply/divide and HI/LO registers.
// Optional MDU_ALU_FAST_MUL_EN: single-cycle combinational MULT/MULTU.
module mdu_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             is_zero,
  output logic             overflow,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_ADDU = 5'd1,  OP_SUB  = 5'd2,  OP_SUBU = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_XOR  = 5'd6,  OP_NOR  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8,  OP_SLTU = 5'd9,  OP_SLL  = 5'd10, OP_SRL  = 5'd11;
  localparam logic [4:0] OP_SRA  = 5'd12, OP_MULT = 5'd16, OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV  = 5'd18, OP_DIVU = 5'd19, OP_MFHI = 5'd20, OP_MFLO = 5'd21;
  localparam logic [4:0] OP_MTHI = 5'd22, OP_MTLO = 5'd23;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   LAST    = SHW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem, quot, dvs, a_orig;
  logic               neg_p, neg_r, dz, dovf;

  logic [WIDTH-1:0] sum, dif, res, hi_n, lo_n;
  logic             res_ovf, res_ill, wr_hi, wr_lo, start_mul, start_div;
  logic             sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [SHW-1:0]   shamt;

  assign in_ready = (state == IDLE);
  assign is_zero  = out_valid && (out == '0);

  assign sum   = in1 + in2;
  assign dif   = in1 - in2;
  assign shamt = in2[SHW-1:0];
  assign sgn   = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag = (sgn && in1[WIDTH-1]) ? -in1 : in1;
  assign b_mag = (sgn && in2[WIDTH-1]) ? -in2 : in2;

`ifdef MDU_ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext1, ext2, fprod;
  assign ext1  = (op == OP_MULT) ? {{WIDTH{in1[WIDTH-1]}}, in1} : {{WIDTH{1'b0}}, in1};
  assign ext2  = (op == OP_MULT) ? {{WIDTH{in2[WIDTH-1]}}, in2} : {{WIDTH{1'b0}}, in2};
  assign fprod = ext1 * ext2;
`endif

  always_comb begin
    res       = '0;
    res_ovf   = 1'b0;
    res_ill   = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    hi_n      = in1;
    lo_n      = in1;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (op)
      OP_ADD:  begin
        res     = sum;
        res_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_ADDU: res = sum;
      OP_SUB:  begin
        res     = dif;
        res_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (dif[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUBU: res = dif;
      OP_AND:  res = in1 & in2;
      OP_OR:   res = in1 | in2;
      OP_XOR:  res = in1 ^ in2;
      OP_NOR:  res = ~(in1 | in2);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, in1 < in2};
      OP_SLL:  res = in1 << shamt;
      OP_SRL:  res = in1 >> shamt;
      OP_SRA:  res = WIDTH'($signed(in1) >>> shamt);
      OP_MULT, OP_MULTU: begin
`ifdef MDU_ALU_FAST_MUL_EN
        res   = fprod[WIDTH-1:0];
        hi_n  = fprod[2*WIDTH-1:WIDTH];
        lo_n  = fprod[WIDTH-1:0];
        wr_hi = 1'b1;
        wr_lo = 1'b1;
`else
        start_mul = 1'b1;
`endif
      end
      OP_DIV, OP_DIVU: start_div = 1'b1;
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      OP_MTHI: begin res = in1; wr_hi = 1'b1; end
      OP_MTLO: begin res = in1; wr_lo = 1'b1; end
      default: res_ill = 1'b1;
    endcase
  end

  // One shift-add step; the last step's sum is the unsigned magnitude product.
  logic [2*WIDTH-1:0] acc_n, prod;
  assign acc_n = acc + (mplier[0] ? mcand : '0);
  assign prod  = neg_p ? -acc_n : acc_n;

  // One restoring-division step: bring in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_n, quot_n, q_fin, r_fin;
  assign shifted = {rem, quot[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign rem_n   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_n  = {quot[WIDTH-2:0], ~diff[WIDTH]};
  assign q_fin   = neg_p ? -quot_n : quot_n;
  assign r_fin   = neg_r ? -rem_n : rem_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      rem       <= '0;
      quot      <= '0;
      dvs       <= '0;
      a_orig    <= '0;
      neg_p     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      dovf      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            if (start_mul) begin
              state  <= MUL;
              cnt    <= '0;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              neg_p  <= sgn && (in1[WIDTH-1] ^ in2[WIDTH-1]);
            end else if (start_div) begin
              state  <= DIV;
              cnt    <= '0;
              rem    <= '0;
              quot   <= a_mag;
              dvs    <= b_mag;
              a_orig <= in1;
              neg_p  <= sgn && (in1[WIDTH-1] ^ in2[WIDTH-1]);
              neg_r  <= sgn && in1[WIDTH-1];
              dz     <= (in2 == '0);
              dovf   <= sgn && (in1 == MIN_VAL) && (in2 == '1);
            end else begin
              out_valid <= 1'b1;
              out       <= res;
              overflow  <= res_ovf;
              illegal   <= res_ill;
              if (wr_hi) hi <= hi_n;
              if (wr_lo) lo <= lo_n;
            end
          end
        end
        MUL: begin
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          out_valid <= 1'b0;
          if (cnt == LAST) begin
            state     <= IDLE;
            hi        <= prod[2*WIDTH-1:WIDTH];
            lo        <= prod[WIDTH-1:0];
            out       <= prod[WIDTH-1:0];
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DIV: begin
          rem  <= rem_n;
          quot <= quot_n;
          cnt  <= cnt + 1'b1;
          out_valid <= 1'b0;
          if (cnt == LAST) begin
            state     <= IDLE;
            hi        <= dz ? a_orig : r_fin;
            lo        <= dz ? '1 : q_fin;
            out       <= dz ? '1 : q_fin;
            overflow  <= dz || dovf;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
